// File: rtl/sram_arbiter.sv
// Two-requester round-robin front end for one synchronous single-port SRAM.
// Ports: CLK, NRST (sync, active-low); A_*/B_* request, write data, grant
// and read-return channels; SRAM_* registered control/address/data toward
// the SRAM macro and SRAM_DOUT from it.
module sram_arbiter #(
    parameter int MEM_ADDR_W = 10,
    parameter int MEM_DATA_W = 32
) (
    input  logic                  CLK,
    input  logic                  NRST,
    input  logic                  A_REQ,
    input  logic                  A_WE,
    input  logic [MEM_ADDR_W-1:0] A_ADDR,
    input  logic [MEM_DATA_W-1:0] A_WDATA,
    output logic                  A_GNT,
    output logic                  A_RVALID,
    output logic [MEM_DATA_W-1:0] A_RDATA,
    input  logic                  B_REQ,
    input  logic                  B_WE,
    input  logic [MEM_ADDR_W-1:0] B_ADDR,
    input  logic [MEM_DATA_W-1:0] B_WDATA,
    output logic                  B_GNT,
    output logic                  B_RVALID,
    output logic [MEM_DATA_W-1:0] B_RDATA,
    output logic                  SRAM_NCE,
    output logic                  SRAM_NWRT,
    output logic                  SRAM_NOE,
    output logic [MEM_ADDR_W-1:0] SRAM_ADDR,
    output logic [MEM_DATA_W-1:0] SRAM_DIN,
    input  logic [MEM_DATA_W-1:0] SRAM_DOUT
);

    // last_q: 1 = B was granted most recently, 0 = A
    logic                  last_q, last_d;
    logic                  nce_q, nwrt_q, noe_q;
    logic [MEM_ADDR_W-1:0] addr_q;
    logic [MEM_DATA_W-1:0] din_q;
    logic                  s1_rd_q, s1_id_q;
    logic                  s2_rd_q, s2_id_q;
    logic                  a_rvalid_q, b_rvalid_q;
    logic [MEM_DATA_W-1:0] a_rdata_q, b_rdata_q;

    logic                  a_win, b_win;
    logic                  gnt_a, gnt_b, gnt_any;
    logic                  sel_we;
    logic [MEM_ADDR_W-1:0] sel_addr;
    logic [MEM_DATA_W-1:0] sel_wdata;

    always_comb begin
        // A wins when alone, or on contention if B went last
        a_win     = A_REQ & (~B_REQ | last_q);
        b_win     = B_REQ & ~a_win;
        gnt_a     = NRST & a_win;
        gnt_b     = NRST & b_win;
        gnt_any   = gnt_a | gnt_b;
        sel_we    = gnt_b ? B_WE : A_WE;
        sel_addr  = gnt_b ? B_ADDR : A_ADDR;
        sel_wdata = gnt_b ? B_WDATA : A_WDATA;
        last_d    = gnt_any ? gnt_b : last_q;
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            last_q     <= 1'b1;
            nce_q      <= 1'b1;
            nwrt_q     <= 1'b1;
            noe_q      <= 1'b1;
            addr_q     <= '0;
            din_q      <= '0;
            s1_rd_q    <= 1'b0;
            s1_id_q    <= 1'b0;
            s2_rd_q    <= 1'b0;
            s2_id_q    <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            last_q  <= last_d;
            // issue stage
            nce_q   <= ~gnt_any;
            nwrt_q  <= ~(gnt_any & sel_we);
            if (gnt_any) begin
                addr_q <= sel_addr;
                din_q  <= sel_wdata;
            end
            s1_rd_q <= gnt_any & ~sel_we;
            s1_id_q <= gnt_b;
            // read stage: SRAM drives DOUT while this stage holds a read
            s2_rd_q <= s1_rd_q;
            s2_id_q <= s1_id_q;
            noe_q   <= ~s1_rd_q;
            // return
            a_rvalid_q <= s2_rd_q & ~s2_id_q;
            b_rvalid_q <= s2_rd_q & s2_id_q;
            if (s2_rd_q && !s2_id_q) a_rdata_q <= SRAM_DOUT;
            if (s2_rd_q && s2_id_q)  b_rdata_q <= SRAM_DOUT;
        end
    end

    assign A_GNT     = gnt_a;
    assign B_GNT     = gnt_b;
    assign A_RVALID  = a_rvalid_q;
    assign B_RVALID  = b_rvalid_q;
    assign A_RDATA   = a_rdata_q;
    assign B_RDATA   = b_rdata_q;
    // Reset masks an access already sitting in S1 before the SRAM samples it
    assign SRAM_NCE  = nce_q | ~NRST;
    assign SRAM_NWRT = nwrt_q | ~NRST;
    assign SRAM_NOE  = noe_q;
    assign SRAM_ADDR = addr_q;
    assign SRAM_DIN  = din_q;

endmodule
